i2s_tx_serializer: RTL and testbench



---
 rtl/i2s_pkg.sv | 18 +
 rtl/i2s_bclk_gen.sv | 44 ++++
 rtl/i2s_tx_serializer.sv | 96 +++++++++
 tb/tb_i2s_tx_serializer.sv | 450 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared constants and helpers for the I2S transmit path.
package i2s_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_SLOT_BITS  = 32;
    localparam int DEF_BCLK_DIV   = 4;

    typedef enum logic {
        LEFT  = 1'b0,
        RIGHT = 1'b1
    } i2s_chan_e;

    // Number of bclk periods in one left/right frame.
    function automatic int frame_len(input int slot_bits);
        return 2 * slot_bits;
    endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// Bit-clock divider: toggles bclk every BCLK_DIV clk cycles and flags the
// cycle in which bclk is about to fall so the serializer can update with it.
module i2s_bclk_gen
    import i2s_pkg::*;
#(
    parameter int BCLK_DIV = DEF_BCLK_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    output logic bclk,
    output logic fall_event
);

    localparam int CNT_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BCLK_DIV - 1);

    if (BCLK_DIV < 1) begin : g_bad_div
        $error("i2s_bclk_gen: BCLK_DIV must be >= 1");
    end

    logic [CNT_W-1:0] div_cnt;
    logic             terminal;

    assign terminal   = (div_cnt == CNT_MAX);
    // High in the cycle whose clk edge drives bclk from 1 to 0.
    assign fall_event = enable && terminal && bclk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
        end else if (!enable) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
        end else if (terminal) begin
            div_cnt <= '0;
            bclk    <= ~bclk;
        end else begin
            div_cnt <= div_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/i2s_tx_serializer.sv
// I2S transmitter: captures a left/right sample pair once per frame and
// shifts it out MSB first, with lrclk leading each slot by one bclk.
module i2s_tx_serializer
    import i2s_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int SLOT_BITS  = DEF_SLOT_BITS,
    parameter int BCLK_DIV   = DEF_BCLK_DIV
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] audio_left_in,
    input  logic [DATA_WIDTH-1:0] audio_right_in,
    output logic                  bclk,
    output logic                  lrclk,
    output logic                  sdata,
    output logic                  frame_tick
);

    localparam int FRAME_LEN = frame_len(SLOT_BITS);
    localparam int P_W       = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
    localparam logic [P_W-1:0] P_LAST  = P_W'(FRAME_LEN - 1);
    localparam logic [P_W-1:0] P_RIGHT = P_W'(SLOT_BITS);

    if (SLOT_BITS < DATA_WIDTH) begin : g_bad_slot
        $error("i2s_tx_serializer: SLOT_BITS must be >= DATA_WIDTH");
    end

    logic                  fall_event;
    logic [P_W-1:0]        p;
    logic [P_W-1:0]        p_next;
    logic [P_W-1:0]        p_after;
    logic [P_W-1:0]        slot_pos;
    i2s_chan_e             chan_next;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [DATA_WIDTH-1:0] right_hold;

    i2s_bclk_gen #(
        .BCLK_DIV(BCLK_DIV)
    ) u_bclk_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .bclk      (bclk),
        .fall_event(fall_event)
    );

    // lrclk is derived from the position after the new one so it switches
    // one bclk before the slot it announces.
    always_comb begin
        p_next    = (p == P_LAST) ? '0 : p + P_W'(1);
        p_after   = (p_next == P_LAST) ? '0 : p_next + P_W'(1);
        chan_next = (p_after >= P_RIGHT) ? RIGHT : LEFT;
        slot_pos  = (p_next >= P_RIGHT) ? p_next - P_RIGHT : p_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p          <= P_LAST;
            lrclk      <= 1'b0;
            sdata      <= 1'b0;
            frame_tick <= 1'b0;
            shift_reg  <= '0;
            right_hold <= '0;
        end else if (!enable) begin
            p          <= P_LAST;
            lrclk      <= 1'b0;
            sdata      <= 1'b0;
            frame_tick <= 1'b0;
            shift_reg  <= '0;
            right_hold <= '0;
        end else begin
            frame_tick <= 1'b0;
            if (fall_event) begin
                p     <= p_next;
                lrclk <= (chan_next == RIGHT);
                if (p_next == '0) begin
                    shift_reg  <= audio_left_in << 1;
                    sdata      <= audio_left_in[DATA_WIDTH-1];
                    right_hold <= audio_right_in;
                    frame_tick <= 1'b1;
                end else if (p_next == P_RIGHT) begin
                    shift_reg <= right_hold << 1;
                    sdata     <= right_hold[DATA_WIDTH-1];
                end else if (int'(slot_pos) < DATA_WIDTH) begin
                    sdata     <= shift_reg[DATA_WIDTH-1];
                    shift_reg <= shift_reg << 1;
                end else begin
                    sdata <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Bench for i2s_tx_serializer: a 16/32/2 instance and a full-width 32/32/1 instance.
`timescale 1ns/1ps
module tb_i2s_tx_serializer;

    localparam int DW0 = 16, SB0 = 32, BD0 = 2;
    localparam int DW1 = 32, SB1 = 32, BD1 = 1;
    localparam logic [63:0] LR_EXP = 64'h0000_0001_FFFF_FFFE;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en0 = 1'b0, en1 = 1'b0;
    logic [DW0-1:0] l0 = '0, r0 = '0;
    logic [DW1-1:0] l1 = '0, r1 = '0;
    logic bclk0, lrclk0, sdata0, tick0;
    logic bclk1, lrclk1, sdata1, tick1;

    int n_checks = 0;
    int n_fail = 0;
    int cyc_n = 0;
    int rst_epoch = 0;
    logic pb0 = 1'b0, pb1 = 1'b0, fall0 = 1'b0, fall1 = 1'b0;

    always #5 clk = ~clk;

    i2s_tx_serializer #(.DATA_WIDTH(DW0), .SLOT_BITS(SB0), .BCLK_DIV(BD0)) u0 (
        .clk(clk), .rst_n(rst_n), .enable(en0),
        .audio_left_in(l0), .audio_right_in(r0),
        .bclk(bclk0), .lrclk(lrclk0), .sdata(sdata0), .frame_tick(tick0)
    );

    i2s_tx_serializer #(.DATA_WIDTH(DW1), .SLOT_BITS(SB1), .BCLK_DIV(BD1)) u1 (
        .clk(clk), .rst_n(rst_n), .enable(en1),
        .audio_left_in(l1), .audio_right_in(r1),
        .bclk(bclk1), .lrclk(lrclk1), .sdata(sdata1), .frame_tick(tick1)
    );

    // Expected {lrclk, sdata} after fall number k of a frame.
    function automatic logic [1:0] exp_fall(input logic [31:0] lw, input logic [31:0] rw,
                                            input int dw, input int sb, input int k);
        int pos;
        logic [31:0] w;
        logic sd, lr;
        pos = k % sb;
        w = (k < sb) ? lw : rw;
        sd = (pos < dw) ? w[dw-1-pos] : 1'b0;
        lr = (((k + 1) % (2 * sb)) >= sb);
        return {lr, sd};
    endfunction

    // Scoreboards: a frame of expected bits is queued at each frame_tick and
    // one entry is consumed at every observed bclk fall.
    logic [1:0] q0[$], q1[$];
    logic [1:0] e0, e1;
    logic pm0 = 1'b0, pm1 = 1'b0;
    logic [31:0] hl0 = '0, hr0 = '0, hl1 = '0, hr1 = '0;
    int seen0 = 0, seen1 = 0;

    always @(negedge clk) begin
        if (!rst_n || !en0 || seen0 != rst_epoch) begin
            seen0 = rst_epoch;
            q0.delete();
        end else begin
            if (tick0 === 1'b1) begin
                n_checks++;
                if (q0.size() != 0) begin
                    n_fail++;
                    $display("FAIL sb0_leftover: %0d entries still queued, required 0", q0.size());
                    q0.delete();
                end
                for (int k = 0; k < 2 * SB0; k++) q0.push_back(exp_fall(hl0, hr0, DW0, SB0, k));
            end
            if (pm0 === 1'b1 && bclk0 === 1'b0) begin
                n_checks++;
                if (q0.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb0_underflow: bclk fall with no frame captured, got sdata %b", sdata0);
                end else begin
                    e0 = q0.pop_front();
                    if ({lrclk0, sdata0} !== e0) begin
                        n_fail++;
                        $display("FAIL sb0_bit: {lrclk,sdata} got %b, required %b (fall %0d)",
                                 {lrclk0, sdata0}, e0, 2 * SB0 - 1 - q0.size());
                    end
                end
            end
        end
        pm0 = bclk0;
        hl0 = 32'(l0);
        hr0 = 32'(r0);
    end

    always @(negedge clk) begin
        if (!rst_n || !en1 || seen1 != rst_epoch) begin
            seen1 = rst_epoch;
            q1.delete();
        end else begin
            if (tick1 === 1'b1) begin
                n_checks++;
                if (q1.size() != 0) begin
                    n_fail++;
                    $display("FAIL sb1_leftover: %0d entries still queued, required 0", q1.size());
                    q1.delete();
                end
                for (int k = 0; k < 2 * SB1; k++) q1.push_back(exp_fall(hl1, hr1, DW1, SB1, k));
            end
            if (pm1 === 1'b1 && bclk1 === 1'b0) begin
                n_checks++;
                if (q1.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb1_underflow: bclk fall with no frame captured, got sdata %b", sdata1);
                end else begin
                    e1 = q1.pop_front();
                    if ({lrclk1, sdata1} !== e1) begin
                        n_fail++;
                        $display("FAIL sb1_bit: {lrclk,sdata} got %b, required %b", {lrclk1, sdata1}, e1);
                    end
                end
            end
        end
        pm1 = bclk1;
        hl1 = l1;
        hr1 = r1;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        cyc_n++;
        fall0 = pb0 && !bclk0;
        fall1 = pb1 && !bclk1;
        pb0 = bclk0;
        pb1 = bclk1;
    endtask

    task automatic drive_random(input int inst);
        if (inst == 0) begin
            l0 = 16'($urandom());
            r0 = 16'($urandom());
        end else begin
            l1 = $urandom();
            r1 = $urandom();
        end
    endtask

    task automatic wait_tick(input int inst, input int limit, output int cnt, output bit ok);
        cnt = 0;
        ok = 1'b0;
        while (!ok && cnt < limit) begin
            cyc();
            cnt++;
            ok = (inst != 0) ? (tick1 === 1'b1) : (tick0 === 1'b1);
        end
    endtask

    task automatic wait_falls(input int inst, input int n, output bit ok);
        int guard;
        logic f;
        ok = 1'b1;
        for (int i = 0; i < n && ok; i++) begin
            guard = 0;
            do begin
                cyc();
                guard++;
                f = (inst != 0) ? fall1 : fall0;
            end while (f !== 1'b1 && guard < 20);
            if (f !== 1'b1) ok = 1'b0;
        end
    endtask

    // Called in the cycle of fall 0; records all 64 falls of the frame.
    task automatic collect(input int inst, input bit rnd, output logic [63:0] sd,
                           output logic [63:0] lr, output bit ok);
        int guard;
        logic f;
        sd = '0;
        lr = '0;
        ok = 1'b1;
        sd[63] = (inst != 0) ? sdata1 : sdata0;
        lr[63] = (inst != 0) ? lrclk1 : lrclk0;
        for (int k = 1; k < 64 && ok; k++) begin
            guard = 0;
            do begin
                if (rnd) drive_random(inst);
                cyc();
                guard++;
                f = (inst != 0) ? fall1 : fall0;
            end while (f !== 1'b1 && guard < 20);
            if (f !== 1'b1) ok = 1'b0;
            else begin
                sd[63-k] = (inst != 0) ? sdata1 : sdata0;
                lr[63-k] = (inst != 0) ? lrclk1 : lrclk0;
            end
        end
    endtask

    task automatic test_reset();
        int cnt;
        bit ok;
        rst_n = 1'b0;
        en0 = 1'b1;
        l0 = 16'hFFFF;
        r0 = 16'hFFFF;
        repeat (5) cyc();
        n_checks++;
        if ({bclk0, lrclk0, sdata0, tick0} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_outputs: {bclk,lrclk,sdata,tick} got %b, required 0000",
                     {bclk0, lrclk0, sdata0, tick0});
        end
        rst_n = 1'b1;
        wait_tick(0, 20, cnt, ok);
        n_checks++;
        if (!ok || cnt != 2 * BD0) begin
            n_fail++;
            $display("FAIL first_tick_latency: got %0d clks (seen %0d), required %0d", cnt, ok, 2 * BD0);
        end
        n_checks++;
        if (fall0 !== 1'b1) begin
            n_fail++;
            $display("FAIL first_fall: bclk fall with first tick got %b, required 1", fall0);
        end
        for (int i = 0; i < 2; i++) begin
            wait_tick(0, 600, cnt, ok);
            n_checks++;
            if (!ok || cnt != 4 * BD0 * SB0) begin
                n_fail++;
                $display("FAIL frame_period: got %0d clks (seen %0d), required %0d", cnt, ok, 4 * BD0 * SB0);
            end
        end
    endtask

    task automatic test_pattern();
        int cnt;
        bit ok;
        logic [63:0] sd, lr;
        l0 = 16'hA5C3;
        r0 = 16'h8001;
        wait_tick(0, 600, cnt, ok);
        collect(0, 1'b0, sd, lr, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL pattern_collect: bclk falls stopped, got ok=%0d, required 1", ok);
        end
        n_checks++;
        if (sd !== {16'hA5C3, 16'h0000, 16'h8001, 16'h0000}) begin
            n_fail++;
            $display("FAIL pattern_sdata: got %h, required %h", sd, {16'hA5C3, 16'h0000, 16'h8001, 16'h0000});
        end
        n_checks++;
        if (lr !== LR_EXP) begin
            n_fail++;
            $display("FAIL pattern_lrclk: got %h, required %h", lr, LR_EXP);
        end
    endtask

    task automatic test_capture();
        int cnt;
        bit ok;
        logic [63:0] sd, lr;
        wait_tick(0, 600, cnt, ok);
        for (int i = 1; i <= 4 * BD0 * SB0 - 1; i++) begin
            cyc();
            if (i == 4 * BD0 * SB0 - 1) begin
                l0 = 16'h1234;
                r0 = 16'h5678;
            end else begin
                drive_random(0);
            end
        end
        cyc();
        n_checks++;
        if (tick0 !== 1'b1) begin
            n_fail++;
            $display("FAIL capture_tick: frame_tick got %b, required 1", tick0);
        end
        collect(0, 1'b1, sd, lr, ok);
        n_checks++;
        if (!ok || sd !== {16'h1234, 16'h0000, 16'h5678, 16'h0000}) begin
            n_fail++;
            $display("FAIL capture_sdata: got %h, required %h", sd, {16'h1234, 16'h0000, 16'h5678, 16'h0000});
        end
    endtask

    task automatic test_back_to_back();
        int cnt;
        bit ok;
        logic [63:0] sd, lr;
        logic [15:0] tl[3] = '{16'h7FFF, 16'h0001, 16'h5A5A};
        logic [15:0] tr[3] = '{16'h8000, 16'hFFFE, 16'hC3C3};
        for (int f = 0; f < 3; f++) begin
            l0 = tl[f];
            r0 = tr[f];
            wait_tick(0, 600, cnt, ok);
            collect(0, 1'b0, sd, lr, ok);
            n_checks++;
            if (!ok || sd !== {tl[f], 16'h0000, tr[f], 16'h0000}) begin
                n_fail++;
                $display("FAIL b2b_frame%0d: got %h, required %h", f, sd, {tl[f], 16'h0000, tr[f], 16'h0000});
            end
        end
    endtask

    task automatic test_enable();
        int cnt;
        bit ok;
        logic [63:0] sd, lr;
        l0 = 16'hFFFF;
        r0 = 16'h0000;
        wait_tick(0, 600, cnt, ok);
        wait_falls(0, 10, ok);
        cyc();
        cyc();
        n_checks++;
        if (!ok || {bclk0, sdata0} !== 2'b11) begin
            n_fail++;
            $display("FAIL en_precond: {bclk,sdata} at p=10 got %b, required 11", {bclk0, sdata0});
        end
        en0 = 1'b0;
        cyc();
        n_checks++;
        if ({bclk0, lrclk0, sdata0, tick0} !== 4'b0000) begin
            n_fail++;
            $display("FAIL en_park: {bclk,lrclk,sdata,tick} got %b, required 0000", {bclk0, lrclk0, sdata0, tick0});
        end
        repeat (5) cyc();
        n_checks++;
        if ({bclk0, lrclk0, sdata0, tick0} !== 4'b0000) begin
            n_fail++;
            $display("FAIL en_hold: {bclk,lrclk,sdata,tick} got %b, required 0000", {bclk0, lrclk0, sdata0, tick0});
        end
        l0 = 16'h8F00;
        r0 = 16'h0F0F;
        en0 = 1'b1;
        wait_tick(0, 20, cnt, ok);
        n_checks++;
        if (!ok || cnt != 2 * BD0 || sdata0 !== 1'b1) begin
            n_fail++;
            $display("FAIL en_restart: got %0d clks sdata %b, required %0d clks sdata 1", cnt, sdata0, 2 * BD0);
        end
        collect(0, 1'b0, sd, lr, ok);
        n_checks++;
        if (!ok || sd !== {16'h8F00, 16'h0000, 16'h0F0F, 16'h0000}) begin
            n_fail++;
            $display("FAIL en_frame: got %h, required %h", sd, {16'h8F00, 16'h0000, 16'h0F0F, 16'h0000});
        end
    endtask

    task automatic test_async_reset();
        int cnt;
        bit ok;
        logic [63:0] sd, lr;
        l0 = 16'h1111;
        r0 = 16'hFFFF;
        wait_tick(0, 600, cnt, ok);
        wait_falls(0, 40, ok);
        cyc();
        cyc();
        n_checks++;
        if (!ok || {bclk0, lrclk0, sdata0} !== 3'b111) begin
            n_fail++;
            $display("FAIL rst_precond: {bclk,lrclk,sdata} at p=40 got %b, required 111", {bclk0, lrclk0, sdata0});
        end
        #1;
        rst_n = 1'b0;
        rst_epoch++;
        #1;
        n_checks++;
        if ({bclk0, lrclk0, sdata0, tick0} !== 4'b0000) begin
            n_fail++;
            $display("FAIL rst_async_clear: {bclk,lrclk,sdata,tick} got %b, required 0000",
                     {bclk0, lrclk0, sdata0, tick0});
        end
        rst_n = 1'b1;
        pb0 = 1'b0;
        l0 = 16'h4321;
        r0 = 16'h8765;
        wait_tick(0, 20, cnt, ok);
        n_checks++;
        if (!ok || cnt != 2 * BD0) begin
            n_fail++;
            $display("FAIL rst_recover_latency: got %0d clks, required %0d", cnt, 2 * BD0);
        end
        collect(0, 1'b0, sd, lr, ok);
        n_checks++;
        if (!ok || sd !== {16'h4321, 16'h0000, 16'h8765, 16'h0000}) begin
            n_fail++;
            $display("FAIL rst_recover_frame: got %h, required %h", sd, {16'h4321, 16'h0000, 16'h8765, 16'h0000});
        end
    endtask

    task automatic test_full_width();
        int cnt, t_first;
        bit ok;
        logic [63:0] sd, lr;
        en0 = 1'b0;
        l1 = 32'hFFFF_FFFE;
        r1 = 32'h0000_0001;
        en1 = 1'b1;
        wait_tick(1, 20, cnt, ok);
        t_first = cyc_n;
        n_checks++;
        if (!ok || cnt != 2 * BD1) begin
            n_fail++;
            $display("FAIL fw_latency: got %0d clks, required %0d", cnt, 2 * BD1);
        end
        collect(1, 1'b0, sd, lr, ok);
        n_checks++;
        if (!ok || sd !== {32'hFFFF_FFFE, 32'h0000_0001}) begin
            n_fail++;
            $display("FAIL fw_sdata: got %h, required %h", sd, {32'hFFFF_FFFE, 32'h0000_0001});
        end
        n_checks++;
        if (sd[63-31] !== 1'b0 || sd[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL fw_lsb: p31 got %b req 0, p63 got %b req 1", sd[63-31], sd[0]);
        end
        n_checks++;
        if (lr !== LR_EXP) begin
            n_fail++;
            $display("FAIL fw_lrclk: got %h, required %h", lr, LR_EXP);
        end
        wait_tick(1, 200, cnt, ok);
        n_checks++;
        if (!ok || cyc_n - t_first != 4 * BD1 * SB1) begin
            n_fail++;
            $display("FAIL fw_period: got %0d clks, required %0d", cyc_n - t_first, 4 * BD1 * SB1);
        end
        wait_falls(1, 2, ok);
    endtask

    initial begin
        test_reset();
        test_pattern();
        test_capture();
        test_back_to_back();
        test_enable();
        test_async_reset();
        test_full_width();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
